// File: rtl/bsr_pkg.sv
// Shared definitions for the barrel shifter/rotator pipeline:
// operation mode encoding and the pipeline latency helper.
package bsr_pkg;

  localparam int unsigned BSR_MODE_W = 3;

  typedef enum logic [BSR_MODE_W-1:0] {
    BSR_SLL = 3'd0,
    BSR_SRL = 3'd1,
    BSR_SRA = 3'd2,
    BSR_ROL = 3'd3,
    BSR_ROR = 3'd4
  } bsr_mode_e;

  // Number of register slices: one per PIPE_STEP mux stages, rounded up.
  function automatic int unsigned bsr_lat(input int unsigned width,
                                          input int unsigned pipe_step);
    int unsigned nstg;
    nstg = int'($clog2(width));
    return (nstg + pipe_step - 1) / pipe_step;
  endfunction

endpackage

// File: rtl/bsr_stage.sv
// One combinational mux stage of the barrel shifter: moves the word by
// SHIFT positions when en is set. Carry ports exist only with BSR_CARRY_EN.
module bsr_stage
  import bsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0]      src,
  input  logic [BSR_MODE_W-1:0] mode,
  input  logic                  en,
`ifdef BSR_CARRY_EN
  input  logic                  cin,
  output logic                  cout,
`endif
  output logic [WIDTH-1:0]      res
);

  // Shift/rotate by SHIFT for the selected mode; reserved modes pass through.
  always_comb begin
    res = src;
    if (en) begin
      case (mode)
        BSR_SLL: res = src << SHIFT;
        BSR_SRL: res = src >> SHIFT;
        BSR_SRA: res = WIDTH'($signed(src) >>> SHIFT);
        BSR_ROL: res = {src[WIDTH-1-SHIFT:0], src[WIDTH-1:WIDTH-SHIFT]};
        BSR_ROR: res = {src[SHIFT-1:0], src[WIDTH-1:SHIFT]};
        default: res = src;
      endcase
    end
  end

`ifdef BSR_CARRY_EN
  // Last bit leaving the word; an idle stage forwards the earlier carry.
  always_comb begin
    cout = cin;
    if (en) begin
      case (mode)
        BSR_SLL, BSR_ROL:          cout = src[WIDTH-SHIFT];
        BSR_SRL, BSR_SRA, BSR_ROR: cout = src[SHIFT-1];
        default:                   cout = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: rtl/barrel_shift_rotate_pipe.sv
// Pipelined barrel shifter/rotator (SLL/SRL/SRA/ROL/ROR) with valid/ready on
// both sides. log2(WIDTH) mux stages, a register slice every PIPE_STEP stages
// and after the last one. Optional carry output: define BSR_CARRY_EN.
module barrel_shift_rotate_pipe
  import bsr_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PIPE_STEP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [BSR_MODE_W-1:0]    in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef BSR_CARRY_EN
  ,
  output logic                     out_carry
`endif
);

  localparam int unsigned NSTG = $clog2(WIDTH);
  localparam int unsigned LAT  = bsr_lat(WIDTH, PIPE_STEP);

  // Mux stages; the first stage of each group reads the previous slice.
  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    localparam int unsigned GRP = s / PIPE_STEP;
    logic [WIDTH-1:0]      src;
    logic [WIDTH-1:0]      res;
    logic [BSR_MODE_W-1:0] mode;
    logic                  en;
`ifdef BSR_CARRY_EN
    logic                  cin;
    logic                  cout;
`endif

    if (GRP == 0) begin : g_ctl_in
      assign en   = in_amt[s];
      assign mode = in_mode;
    end else begin : g_ctl_sl
      assign en   = g_slice[GRP-1].g_ctl.amt[s - GRP*PIPE_STEP];
      assign mode = g_slice[GRP-1].g_ctl.mode;
    end

    if (s % PIPE_STEP != 0) begin : g_chain
      assign src = g_stage[s-1].res;
`ifdef BSR_CARRY_EN
      assign cin = g_stage[s-1].cout;
`endif
    end else if (GRP == 0) begin : g_head_in
      assign src = in_data;
`ifdef BSR_CARRY_EN
      assign cin = 1'b0;
`endif
    end else begin : g_head_sl
      assign src = g_slice[GRP-1].data;
`ifdef BSR_CARRY_EN
      assign cin = g_slice[GRP-1].carry;
`endif
    end

    bsr_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << s)
    ) u_stage (
      .src  (src),
      .mode (mode),
      .en   (en),
`ifdef BSR_CARRY_EN
      .cin  (cin),
      .cout (cout),
`endif
      .res  (res)
    );
  end

  // Register slices with the advance chain running back from out_ready.
  for (genvar g = 0; g < LAT; g++) begin : g_slice
    localparam int unsigned LAST =
      (((g + 1) * PIPE_STEP < NSTG) ? (g + 1) * PIPE_STEP : NSTG) - 1;
    logic             adv;
    logic             vin;
    logic             v;
    logic [WIDTH-1:0] data;
`ifdef BSR_CARRY_EN
    logic             carry;
`endif

    if (g == LAT - 1) begin : g_adv_last
      assign adv = !v || out_ready;
    end else begin : g_adv_mid
      assign adv = !v || g_slice[g+1].adv;
    end

    if (g == 0) begin : g_vin_in
      assign vin = in_valid;
    end else begin : g_vin_sl
      assign vin = g_slice[g-1].v;
    end

    // Slice valid/data: load on advance, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v    <= 1'b0;
        data <= '0;
`ifdef BSR_CARRY_EN
        carry <= 1'b0;
`endif
      end else if (adv) begin
        v <= vin;
        if (vin) begin
          data <= g_stage[LAST].res;
`ifdef BSR_CARRY_EN
          carry <= g_stage[LAST].cout;
`endif
        end
      end
    end

    // Only amount bits still to be applied travel on; the last slice needs none.
    if (g < LAT - 1) begin : g_ctl
      localparam int unsigned REM = NSTG - (g + 1) * PIPE_STEP;
      logic [REM-1:0]        amt;
      logic [REM-1:0]        amt_in;
      logic [BSR_MODE_W-1:0] mode;
      logic [BSR_MODE_W-1:0] mode_in;

      if (g == 0) begin : g_src_in
        assign amt_in  = in_amt[NSTG-1:PIPE_STEP];
        assign mode_in = in_mode;
      end else begin : g_src_sl
        assign amt_in  = g_slice[g-1].g_ctl.amt[REM+PIPE_STEP-1:PIPE_STEP];
        assign mode_in = g_slice[g-1].g_ctl.mode;
      end

      // Remaining amount and mode fields, frozen while the slice is stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          amt  <= '0;
          mode <= '0;
        end else if (adv && vin) begin
          amt  <= amt_in;
          mode <= mode_in;
        end
      end
    end
  end

  assign in_ready  = g_slice[0].adv;
  assign out_valid = g_slice[LAT-1].v;
  assign out_data  = g_slice[LAT-1].data;
`ifdef BSR_CARRY_EN
  assign out_carry = g_slice[LAT-1].carry;
`endif

endmodule
